// File: rtl/pc_fetch_unit.sv
// RV32I instruction-fetch front end: PC register, single-outstanding imem handshake,
// registered decode output with one-entry skid. Optional macro: PC_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    input  logic        stall,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        trap_misalign
);

`ifdef PC_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2, S_TRAP = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_HOLD = 2'd2} state_t;
`endif

    state_t      state_q;
    logic [31:0] pc_q;
    logic        if_valid_q;
    logic [31:0] if_inst_q;
    logic [31:0] if_pc_q;
    logic [31:0] skid_inst_q;
    logic [31:0] skid_pc_q;
    logic        kill_q;
    logic        consume_d;
    logic        resp_pending_d;

    assign pc_plus4  = pc_q + 32'd4;
    assign pc        = pc_q;
    assign imem_addr = pc_q;
    assign imem_req  = !rst && (state_q == S_REQ) && !(if_valid_q && stall);
    assign consume_d = if_valid_q && !stall;

    // A response still owed by memory after this edge; a redirect must kill it.
    // A response arriving in the redirect cycle itself is simply dropped.
`ifdef PC_MISALIGN_TRAP_EN
    logic trap_q;
    logic misalign_d;
    assign misalign_d     = |next_pc[1:0];
    assign trap_misalign  = trap_q;
    assign resp_pending_d = ((state_q == S_WAIT) && !imem_rvalid) || (imem_req && imem_gnt) ||
                            ((state_q == S_TRAP) && kill_q && !imem_rvalid);
`else
    assign trap_misalign  = 1'b0;
    assign resp_pending_d = ((state_q == S_WAIT) && !imem_rvalid) || (imem_req && imem_gnt);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            if_valid_q  <= 1'b0;
            if_inst_q   <= '0;
            if_pc_q     <= '0;
            skid_inst_q <= '0;
            skid_pc_q   <= '0;
            kill_q      <= 1'b0;
`ifdef PC_MISALIGN_TRAP_EN
            trap_q      <= 1'b0;
`endif
        end else if (redirect) begin
            if_valid_q <= 1'b0;
            kill_q     <= resp_pending_d;
`ifdef PC_MISALIGN_TRAP_EN
            if (misalign_d) begin
                trap_q  <= 1'b1;
                state_q <= S_TRAP;
            end else begin
                trap_q  <= 1'b0;
                pc_q    <= next_pc;
                state_q <= resp_pending_d ? S_WAIT : S_REQ;
            end
`else
            pc_q    <= next_pc & 32'hFFFF_FFFC;
            state_q <= resp_pending_d ? S_WAIT : S_REQ;
`endif
        end else begin
`ifdef PC_MISALIGN_TRAP_EN
            trap_q <= 1'b0;
`endif
            if (consume_d)
                if_valid_q <= 1'b0;
            case (state_q)
                S_REQ: begin
                    if (imem_req && imem_gnt)
                        state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        if (kill_q) begin
                            kill_q  <= 1'b0;
                            state_q <= S_REQ;
                        end else if (!if_valid_q || !stall) begin
                            if_valid_q <= 1'b1;
                            if_inst_q  <= imem_rdata;
                            if_pc_q    <= pc_q;
                            pc_q       <= pc_plus4;
                            state_q    <= S_REQ;
                        end else begin
                            skid_inst_q <= imem_rdata;
                            skid_pc_q   <= pc_q;
                            pc_q        <= pc_plus4;
                            state_q     <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        if_valid_q <= 1'b1;
                        if_inst_q  <= skid_inst_q;
                        if_pc_q    <= skid_pc_q;
                        state_q    <= S_REQ;
                    end
                end
`ifdef PC_MISALIGN_TRAP_EN
                S_TRAP: begin
                    if (imem_rvalid)
                        kill_q <= 1'b0;
                end
`endif
                default: state_q <= S_REQ;
            endcase
        end
    end

    assign if_valid = if_valid_q;
    assign if_inst  = if_inst_q;
    assign if_pc    = if_pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: cycle table plus hand sequences for
// misaligned redirect, reset during a response, and PC wrap (second instance).
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] next_pc = '0;
    logic        redirect = 1'b0;
    logic        stall = 1'b0;
    logic        rv_en = 1'b1;
    logic [31:0] pc_plus4, pc, imem_addr, imem_rdata, if_inst, if_pc;
    logic        imem_req, imem_gnt, imem_rvalid, if_valid, trap_misalign;

    logic [31:0] w_pc_plus4, w_pc, w_imem_addr, w_imem_rdata, w_if_inst, w_if_pc;
    logic        w_imem_req, w_imem_gnt, w_imem_rvalid, w_if_valid, w_trap;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] wq[$];

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(32'h0000_0100)) u_dut (
        .clk(clk), .rst(rst), .next_pc(next_pc), .redirect(redirect), .stall(stall),
        .pc_plus4(pc_plus4), .pc(pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .trap_misalign(trap_misalign)
    );

    pc_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst), .next_pc(32'h0), .redirect(1'b0), .stall(1'b0),
        .pc_plus4(w_pc_plus4), .pc(w_pc), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_gnt(w_imem_gnt), .imem_rvalid(w_imem_rvalid), .imem_rdata(w_imem_rdata),
        .if_valid(w_if_valid), .if_inst(w_if_inst), .if_pc(w_if_pc), .trap_misalign(w_trap)
    );

    // Zero-wait memory returning the address as the instruction word.
    logic        m_pend = 1'b0;
    logic [31:0] m_addr = '0;
    assign imem_gnt    = imem_req;
    assign imem_rvalid = m_pend && rv_en;
    assign imem_rdata  = m_addr;
    always @(posedge clk) begin
        if (imem_rvalid) m_pend <= 1'b0;
        if (imem_req && imem_gnt) begin
            m_pend <= 1'b1;
            m_addr <= imem_addr;
        end
    end

    logic        w_pend = 1'b0;
    logic [31:0] w_addr = '0;
    assign w_imem_gnt    = w_imem_req;
    assign w_imem_rvalid = w_pend;
    assign w_imem_rdata  = w_addr;
    always @(posedge clk) begin
        if (w_imem_rvalid) w_pend <= 1'b0;
        if (w_imem_req && w_imem_gnt) begin
            w_pend <= 1'b1;
            w_addr <= w_imem_addr;
        end
    end

    always @(negedge clk)
        if (!rst && w_if_valid) wq.push_back(w_if_pc);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rd, input logic [31:0] np,
                         input logic st, input logic rv);
        @(posedge clk);
        #1;
        rst = r; redirect = rd; next_pc = np; stall = st; rv_en = rv;
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst, redir;
        logic [31:0] npc;
        logic        stall, rv;
        logic        e_req, e_vld;
        logic [31:0] e_ifpc, e_pc;
    } vec_t;

    vec_t tbl[18];

    initial begin
        bit found;
        //            rst   redir  npc           stall rv    req   vld   if_pc         pc
        tbl[0]  = '{1'b1, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h100};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h100};
        tbl[2]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h100};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'h104};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h104};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 32'h108};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 32'h108};
        tbl[7]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 32'h108};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 32'h108};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 1'b0, 1'b1, 32'h104, 32'h108};
        tbl[10] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'h108};
        tbl[11] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 32'h104, 32'h108};
        tbl[12] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'h108, 32'h10C};
        tbl[13] = '{1'b0, 1'b1, 32'h400,     1'b0, 1'b0, 1'b0, 1'b0, 32'h108, 32'h10C};
        tbl[14] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 32'h400};
        tbl[15] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b0, 32'h108, 32'h400};
        tbl[16] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0, 32'h108, 32'h400};
        tbl[17] = '{1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 1'b1, 1'b1, 32'h400, 32'h404};

        for (int i = 0; i < 18; i++) begin
            drive(tbl[i].rst, tbl[i].redir, tbl[i].npc, tbl[i].stall, tbl[i].rv);
            chk($sformatf("row%0d imem_req", i), {31'b0, imem_req}, {31'b0, tbl[i].e_req});
            chk($sformatf("row%0d if_valid", i), {31'b0, if_valid}, {31'b0, tbl[i].e_vld});
            chk($sformatf("row%0d if_pc", i), if_pc, tbl[i].e_ifpc);
            chk($sformatf("row%0d pc", i), pc, tbl[i].e_pc);
            chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_pc);
            chk($sformatf("row%0d pc_plus4", i), pc_plus4, tbl[i].e_pc + 32'd4);
            chk($sformatf("row%0d trap", i), {31'b0, trap_misalign}, 32'h0);
            if (tbl[i].e_vld)
                chk($sformatf("row%0d if_inst", i), if_inst, tbl[i].e_ifpc);
        end

        // Misaligned redirect to 0x402, in the same cycle as the 0x404 response.
        drive(1'b0, 1'b1, 32'h402, 1'b0, 1'b1);
        chk("mis0 imem_rvalid", {31'b0, imem_rvalid}, 32'h1);
        chk("mis0 trap", {31'b0, trap_misalign}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
`ifdef PC_MISALIGN_TRAP_EN
        chk("mis1 trap", {31'b0, trap_misalign}, 32'h1);
        chk("mis1 imem_req", {31'b0, imem_req}, 32'h0);
        chk("mis1 pc", pc, 32'h404);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("mis2 trap", {31'b0, trap_misalign}, 32'h0);
        chk("mis2 imem_req", {31'b0, imem_req}, 32'h0);
        drive(1'b0, 1'b1, 32'h500, 1'b0, 1'b1);
        chk("mis3 imem_req", {31'b0, imem_req}, 32'h0);
        chk("mis3 if_valid", {31'b0, if_valid}, 32'h0);
`else
        chk("mis1 trap", {31'b0, trap_misalign}, 32'h0);
        chk("mis1 imem_req", {31'b0, imem_req}, 32'h1);
        chk("mis1 pc", pc, 32'h400);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("mis2 imem_req", {31'b0, imem_req}, 32'h0);
        drive(1'b0, 1'b1, 32'h500, 1'b0, 1'b1);
        chk("mis3 if_valid", {31'b0, if_valid}, 32'h1);
        chk("mis3 if_pc", if_pc, 32'h400);
        chk("mis3 if_inst", if_inst, 32'h400);
`endif
        found = 1'b0;
        for (int k = 0; k < 10 && !found; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            chk($sformatf("mis wait%0d trap", k), {31'b0, trap_misalign}, 32'h0);
            found = if_valid;
        end
        chk("after redirect found", {31'b0, found}, 32'h1);
        chk("after redirect if_pc", if_pc, 32'h500);
        chk("after redirect if_inst", if_inst, 32'h500);

        // Reset while the 0x504 response arrives.
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("rst imem_rvalid", {31'b0, imem_rvalid}, 32'h1);
        chk("rst imem_req", {31'b0, imem_req}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("post-rst if_valid", {31'b0, if_valid}, 32'h0);
        chk("post-rst if_pc", if_pc, 32'h0);
        chk("post-rst if_inst", if_inst, 32'h0);
        chk("post-rst pc", pc, 32'h100);
        chk("post-rst imem_addr", imem_addr, 32'h100);
        chk("post-rst imem_req", {31'b0, imem_req}, 32'h1);
        chk("post-rst trap", {31'b0, trap_misalign}, 32'h0);
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            found = if_valid;
        end
        chk("post-rst found", {31'b0, found}, 32'h1);
        chk("post-rst first if_pc", if_pc, 32'h100);
        chk("post-rst first if_inst", if_inst, 32'h100);

        // Wrapping instance: first three deliveries after the initial reset.
        chk("wrap count>=3", {31'b0, wq.size() >= 3}, 32'h1);
        if (wq.size() >= 3) begin
            chk("wrap if_pc0", wq[0], 32'hFFFF_FFF8);
            chk("wrap if_pc1", wq[1], 32'hFFFF_FFFC);
            chk("wrap if_pc2", wq[2], 32'h0000_0000);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
